arithmetic_left_shift_saturating_serial: RTL and testbench

- Sequential counterpart to the arithmetic right shift / signed divide-by-2^S blocks: signed multiply by 2^shamt, done as an arithmetic left shift.
- Shifts one bit per clock. Detects signed overflow and saturates the result to the N-bit signed range.
- Sits between valid/ready producer and consumer stages in the arithmetic pipeline exercises.
- Used as the golden "scale-up" partner for the divide-by-power-of-2 modules.

---
 rtl/arithmetic_left_shift_saturating_serial.sv | 106 ++++++++++
 tb/tb_arithmetic_left_shift_saturating_serial.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/arithmetic_left_shift_saturating_serial.sv
// Serial saturating arithmetic left shift: res = clamp(a * 2^shamt) to the
// N-bit signed range, one shift per clock, valid/ready on both sides.
// Latency is exactly shamt cycles from accept to out_valid (shamt=0 -> next cycle).
module arithmetic_left_shift_saturating_serial #(
   parameter int N  = 8,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] shamt,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  res,
   output logic          ovf,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   state_t        state;
   logic [N-1:0]  acc;
   logic [SW-1:0] cnt;
   logic          sign;
   logic          ovf_sticky;

   logic          step_ovf;
   logic          ovf_next;
   logic [N-1:0]  acc_shl;
   logic [N-1:0]  sat_val;

   // Overflow on this shift: the two top bits disagree, so shifting would
   // change the sign. The final-edge result folds in the last shift's check.
   always_comb begin
      step_ovf = acc[N-1] ^ acc[N-2];
      ovf_next = ovf_sticky | step_ovf;
      acc_shl  = {acc[N-2:0], 1'b0};
      sat_val  = sign ? MIN_NEG : MAX_POS;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         res        <= '0;
         ovf        <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         sign       <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc        <= a;
                  sign       <= a[N-1];
                  cnt        <= shamt;
                  ovf_sticky <= 1'b0;
                  in_ready   <= 1'b0;
                  if (shamt == '0) begin
                     // Nothing to shift: the operand is the exact result.
                     res       <= a;
                     ovf       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc        <= acc_shl;
               cnt        <= cnt - 1'b1;
               ovf_sticky <= ovf_next;
               // Always run the full count so latency does not depend on data.
               if (cnt == SW'(1)) begin
                  res       <= ovf_next ? sat_val : acc_shl;
                  ovf       <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // res/ovf hold until the consumer takes them.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arithmetic_left_shift_saturating_serial.sv
// Directed + random bench for the serial saturating left shifter (N=8, SW=4).
module tb_arithmetic_left_shift_saturating_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [3:0] shamt;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] res;
   logic       ovf;
   logic       out_valid;
   logic       out_ready;

   int n_chk  = 0;
   int n_fail = 0;

   arithmetic_left_shift_saturating_serial #(.N(8), .SW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .shamt     (shamt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res       (res),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Clamp model of a * 2^s in the 8-bit signed range.
   task automatic model(input logic [7:0] av, input logic [3:0] sv,
                        output logic [7:0] r, output logic o);
      longint v;
      v = longint'($signed(av)) * (longint'(1) << sv);
      if (v > 127) begin
         r = 8'h7F; o = 1'b1;
      end else if (v < -128) begin
         r = 8'h80; o = 1'b1;
      end else begin
         r = v[7:0]; o = 1'b0;
      end
   endtask

   // Issue one op at a negedge, measure latency, optionally stall the
   // consumer for `hold` cycles while poking in_valid, then hand off.
   task automatic do_op(input logic [7:0] av, input logic [3:0] sv,
                        input logic [7:0] er, input logic eo, input int hold);
      int lat;
      chk("in_ready_idle", in_ready, 1);
      a = av; shamt = sv; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, sv);
      chk("res", res, er);
      chk("ovf", ovf, eo);
      chk("in_ready_busy", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 8'h55; shamt = 4'd0;
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_res", res, er);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("handoff_valid", out_valid, 0);
      chk("handoff_ready", in_ready, 1);
   endtask

   initial begin
      logic [7:0] er;
      logic       eo;
      logic [7:0] ra;
      logic [3:0] rs;
      rst = 1'b1; a = '0; shamt = '0; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op(8'h05, 4'd3,  8'h28, 1'b0, 0);
      do_op(8'hFD, 4'd2,  8'hF4, 1'b0, 0);
      do_op(8'hFF, 4'd0,  8'hFF, 1'b0, 0);
      do_op(8'h14, 4'd3,  8'h7F, 1'b1, 0);
      do_op(8'h9C, 4'd1,  8'h80, 1'b1, 0);
      do_op(8'h00, 4'd15, 8'h00, 1'b0, 0);
      do_op(8'h80, 4'd1,  8'h80, 1'b1, 0);
      do_op(8'hFF, 4'd7,  8'h80, 1'b0, 0);
      do_op(8'h40, 4'd1,  8'h7F, 1'b1, 0);
      do_op(8'h01, 4'd8,  8'h7F, 1'b1, 0);
      do_op(8'h07, 4'd1,  8'h0E, 1'b0, 5);

      // Asynchronous reset in the middle of a long shift.
      a = 8'h03; shamt = 4'd10; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_res", res, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(8'h03, 4'd2, 8'h0C, 1'b0, 0);

      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom);
         rs = 4'($urandom_range(0, 15));
         model(ra, rs, er, eo);
         do_op(ra, rs, er, eo, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
